// File: rtl/aclock_set_ctrl.sv
// Button-driven hour/minute setting controller feeding the alarm-clock core's BCD load bus.
// Optional feature macro: AUTO_REPEAT_EN (held btn_inc auto-repeats after RPT_DLY cycles).
module aclock_set_ctrl #(
   parameter int unsigned LD_HOLD = 12,
   parameter int unsigned TIMEOUT = 1000
`ifdef AUTO_REPEAT_EN
   ,
   parameter int unsigned RPT_DLY = 200,
   parameter int unsigned RPT_PER = 25
`endif
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic       btn_cancel,
   input  logic       sel_alarm,
   output logic [1:0] H_in1,
   output logic [3:0] H_in0,
   output logic [3:0] M_in1,
   output logic [3:0] M_in0,
   output logic       LD_time,
   output logic       LD_alarm,
   output logic [1:0] edit_fld,
   output logic       busy
);

   localparam int unsigned LD_W  = $clog2(LD_HOLD + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EDIT_H = 2'd1,
      S_EDIT_M = 2'd2,
      S_LOAD   = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [4:0]       r_hour, w_hour_nxt;
   logic [5:0]       r_min, w_min_nxt;
   logic             r_target, w_target_nxt;
   logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
   logic [LD_W-1:0]  r_ld_cnt, w_ld_cnt_nxt;
   logic             r_inc_q, r_dec_q;
   logic             w_inc_edge, w_dec_edge, w_rpt_step;
   logic             w_up, w_dn, w_event, w_edit;
   logic [1:0]       w_fld;

   function automatic logic [3:0] tens_of(input logic [5:0] v);
      if (v >= 6'd50)      return 4'd5;
      else if (v >= 6'd40) return 4'd4;
      else if (v >= 6'd30) return 4'd3;
      else if (v >= 6'd20) return 4'd2;
      else if (v >= 6'd10) return 4'd1;
      else                 return 4'd0;
   endfunction

   function automatic logic [3:0] units_of(input logic [5:0] v);
      return 4'(v - 6'(tens_of(v)) * 6'd10);
   endfunction

   assign w_edit     = (r_state == S_EDIT_H) || (r_state == S_EDIT_M);
   assign w_inc_edge = btn_inc & ~r_inc_q;
   assign w_dec_edge = btn_dec & ~r_dec_q;
   // Simultaneous up and down requests cancel each other out.
   assign w_up       = (w_inc_edge | w_rpt_step) & ~w_dec_edge;
   assign w_dn       = w_dec_edge & ~(w_inc_edge | w_rpt_step);
   assign w_event    = btn_mode | btn_cancel | w_inc_edge | w_dec_edge | w_rpt_step;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RPT_W = $clog2(RPT_DLY + 1);

   logic [RPT_W-1:0] r_rpt, w_rpt_nxt;

   // Counter reloads after each step so later steps land every RPT_PER cycles.
   assign w_rpt_step = w_edit & btn_inc & r_inc_q & (r_rpt == RPT_W'(RPT_DLY));

   always_comb begin
      w_rpt_nxt = '0;
      if (w_edit && btn_inc && (w_state_nxt == r_state)) begin
         if (w_rpt_step) w_rpt_nxt = RPT_W'(RPT_DLY - RPT_PER + 1);
         else            w_rpt_nxt = r_rpt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_rpt <= '0;
      else          r_rpt <= w_rpt_nxt;
   end
`else
   assign w_rpt_step = 1'b0;
`endif

   // Next-state and value update logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_hour_nxt   = r_hour;
      w_min_nxt    = r_min;
      w_target_nxt = r_target;
      w_tmo_nxt    = '0;
      w_ld_cnt_nxt = '0;
      case (r_state)
         S_IDLE: begin
            if (btn_mode) begin
               w_state_nxt  = S_EDIT_H;
               w_target_nxt = sel_alarm;
            end
         end
         S_EDIT_H: begin
            if (w_up)      w_hour_nxt = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
            else if (w_dn) w_hour_nxt = (r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1;
            if (btn_mode) w_state_nxt = S_EDIT_M;
         end
         S_EDIT_M: begin
            if (w_up)      w_min_nxt = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
            else if (w_dn) w_min_nxt = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
            if (btn_mode) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (r_ld_cnt == LD_W'(LD_HOLD)) w_state_nxt = S_IDLE;
            else                            w_ld_cnt_nxt = r_ld_cnt + 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Cancel overrides mode; inactivity abandons the edit.
      if (w_edit) begin
         if (w_event) w_tmo_nxt = '0;
         else         w_tmo_nxt = r_tmo + 1'b1;
         if (btn_cancel) w_state_nxt = S_IDLE;
         else if (!w_event && (r_tmo == TMO_W'(TIMEOUT - 1))) w_state_nxt = S_IDLE;
      end
   end

   always_comb begin
      w_fld = 2'b00;
      if (w_state_nxt == S_EDIT_H)      w_fld = 2'b01;
      else if (w_state_nxt == S_EDIT_M) w_fld = 2'b10;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_hour   <= '0;
         r_min    <= '0;
         r_target <= 1'b0;
         r_tmo    <= '0;
         r_ld_cnt <= '0;
         r_inc_q  <= 1'b0;
         r_dec_q  <= 1'b0;
         H_in1    <= '0;
         H_in0    <= '0;
         M_in1    <= '0;
         M_in0    <= '0;
         LD_time  <= 1'b0;
         LD_alarm <= 1'b0;
         edit_fld <= '0;
         busy     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_hour   <= w_hour_nxt;
         r_min    <= w_min_nxt;
         r_target <= w_target_nxt;
         r_tmo    <= w_tmo_nxt;
         r_ld_cnt <= w_ld_cnt_nxt;
         r_inc_q  <= btn_inc;
         r_dec_q  <= btn_dec;
         H_in1    <= 2'(tens_of({1'b0, r_hour}));
         H_in0    <= units_of({1'b0, r_hour});
         M_in1    <= tens_of(r_min);
         M_in0    <= units_of(r_min);
         // Strobe rises the cycle after LOAD entry and lasts LD_HOLD cycles.
         LD_time  <= (r_state == S_LOAD) && (r_ld_cnt < LD_W'(LD_HOLD)) && !r_target;
         LD_alarm <= (r_state == S_LOAD) && (r_ld_cnt < LD_W'(LD_HOLD)) && r_target;
         edit_fld <= w_fld;
         busy     <= (w_state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_aclock_set_ctrl.sv
// Directed self-checking bench for aclock_set_ctrl: load paths, wraps, cancel, timeout, reset in LOAD.
module tb_aclock_set_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0;
   logic       sel_alarm = 1'b0;
   logic [1:0] H_in1;
   logic [3:0] H_in0, M_in1, M_in0;
   logic       LD_time, LD_alarm, busy;
   logic [1:0] edit_fld;

   int checks = 0;
   int errors = 0;
   int ld_t = 0;
   int ld_a = 0;
   int both_hi = 0;

   aclock_set_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .btn_cancel(btn_cancel), .sel_alarm(sel_alarm),
      .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
      .LD_time(LD_time), .LD_alarm(LD_alarm),
      .edit_fld(edit_fld), .busy(busy)
   );

   always #5 clk = ~clk;

   // Strobe-length monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (LD_time)  ld_t++;
      if (LD_alarm) ld_a++;
      if (LD_time && LD_alarm) both_hi++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse_mode();
      btn_mode = 1'b1; tick(); btn_mode = 1'b0;
   endtask

   task automatic press_inc();
      btn_inc = 1'b1; tick(); btn_inc = 1'b0; tick();
   endtask

   task automatic press_dec();
      btn_dec = 1'b1; tick(); btn_dec = 1'b0; tick();
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      {btn_mode, btn_inc, btn_dec, btn_cancel, sel_alarm} = '0;
      tick_n(2);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #2;
      checks++;
      if ({H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin
         errors++; $display("FAIL reset_bcd: got %0d%0d:%0d%0d want 00:00", H_in1, H_in0, M_in1, M_in0);
      end
      checks++;
      if ({LD_time, LD_alarm, busy, edit_fld} !== 5'd0) begin
         errors++; $display("FAIL reset_ctrl: got LDt=%0b LDa=%0b busy=%0b fld=%0d want all 0",
                            LD_time, LD_alarm, busy, edit_fld);
      end
      apply_reset();
   endtask

   // Scenario: set 13:05 into the time registers.
   task automatic test_time_load();
      int n;
      apply_reset();
      pulse_mode();
      checks++;
      if (edit_fld !== 2'b01 || busy !== 1'b1) begin
         errors++; $display("FAIL t1_edit_h: got fld=%0d busy=%0b want fld=1 busy=1", edit_fld, busy);
      end
      repeat (13) press_inc();
      checks++;
      if (H_in1 !== 2'd1 || H_in0 !== 4'd3) begin
         errors++; $display("FAIL t1_hour: got %0d%0d want 13", H_in1, H_in0);
      end
      pulse_mode();
      checks++;
      if (edit_fld !== 2'b10) begin
         errors++; $display("FAIL t1_edit_m: got fld=%0d want 2", edit_fld);
      end
      repeat (5) press_inc();
      ld_t = 0; ld_a = 0;
      pulse_mode();
      checks++;
      if (LD_time !== 1'b0 || busy !== 1'b1 || edit_fld !== 2'b00) begin
         errors++; $display("FAIL t1_load_entry: got LDt=%0b busy=%0b fld=%0d want 0 1 0", LD_time, busy, edit_fld);
      end
      tick();
      checks++;
      if (LD_time !== 1'b1) begin
         errors++; $display("FAIL t1_ld_rise: got %0b want 1", LD_time);
      end
      wait_idle(n);
      checks++;
      if (n >= 40) begin
         errors++; $display("FAIL t1_idle_timeout: got busy=%0b after %0d cycles want 0", busy, n);
      end
      checks++;
      if (ld_t !== 12 || ld_a !== 0 || LD_time !== 1'b0) begin
         errors++; $display("FAIL t1_strobe: got LDt cycles=%0d LDa cycles=%0d want 12 0", ld_t, ld_a);
      end
      checks++;
      if ({H_in1, H_in0, M_in1, M_in0} !== {2'd1, 4'd3, 4'd0, 4'd5}) begin
         errors++; $display("FAIL t1_bcd: got %0d%0d:%0d%0d want 13:05", H_in1, H_in0, M_in1, M_in0);
      end
   endtask

   // Scenario: dec from 00:00 into the alarm registers.
   task automatic test_alarm_load();
      int n;
      apply_reset();
      sel_alarm = 1'b1;
      pulse_mode();
      sel_alarm = 1'b0;
      press_dec();
      pulse_mode();
      press_dec();
      ld_t = 0; ld_a = 0; both_hi = 0;
      pulse_mode();
      wait_idle(n);
      checks++;
      if (n >= 40) begin
         errors++; $display("FAIL t2_idle_timeout: got busy=%0b after %0d cycles want 0", busy, n);
      end
      checks++;
      if (ld_a !== 12 || ld_t !== 0 || both_hi !== 0) begin
         errors++; $display("FAIL t2_strobe: got LDa=%0d LDt=%0d both=%0d want 12 0 0", ld_a, ld_t, both_hi);
      end
      checks++;
      if ({H_in1, H_in0, M_in1, M_in0} !== {2'd2, 4'd3, 4'd5, 4'd9}) begin
         errors++; $display("FAIL t2_bcd: got %0d%0d:%0d%0d want 23:59", H_in1, H_in0, M_in1, M_in0);
      end
   endtask

   task automatic test_wrap();
      int n;
      apply_reset();
      pulse_mode();
      press_dec();
      checks++;
      if (H_in1 !== 2'd2 || H_in0 !== 4'd3) begin
         errors++; $display("FAIL t3_hour_dec_wrap: got %0d%0d want 23", H_in1, H_in0);
      end
      press_inc();
      checks++;
      if (H_in1 !== 2'd0 || H_in0 !== 4'd0) begin
         errors++; $display("FAIL t3_hour_inc_wrap: got %0d%0d want 00", H_in1, H_in0);
      end
      pulse_mode();
      press_dec();
      checks++;
      if ({H_in1, H_in0, M_in1, M_in0} !== {2'd0, 4'd0, 4'd5, 4'd9}) begin
         errors++; $display("FAIL t3_min_dec_wrap: got %0d%0d:%0d%0d want 00:59", H_in1, H_in0, M_in1, M_in0);
      end
      press_inc();
      checks++;
      if ({H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin
         errors++; $display("FAIL t3_min_inc_wrap: got %0d%0d:%0d%0d want 00:00", H_in1, H_in0, M_in1, M_in0);
      end
      btn_inc = 1'b1; btn_dec = 1'b1; tick();
      btn_inc = 1'b0; btn_dec = 1'b0; tick();
      checks++;
      if ({M_in1, M_in0} !== 8'd0) begin
         errors++; $display("FAIL t3_inc_dec_same: got %0d%0d want 00", M_in1, M_in0);
      end
      // Mode with inc: value steps first, then LOAD.
      ld_t = 0; ld_a = 0;
      btn_inc = 1'b1; btn_mode = 1'b1; tick();
      btn_inc = 1'b0; btn_mode = 1'b0;
      checks++;
      if (busy !== 1'b1 || edit_fld !== 2'b00) begin
         errors++; $display("FAIL t3_mode_inc_state: got busy=%0b fld=%0d want 1 0", busy, edit_fld);
      end
      wait_idle(n);
      checks++;
      if (n >= 40 || ld_t !== 12 || ld_a !== 0) begin
         errors++; $display("FAIL t3_mode_inc_load: got cycles=%0d LDt=%0d LDa=%0d want <40 12 0", n, ld_t, ld_a);
      end
      checks++;
      if ({H_in1, H_in0, M_in1, M_in0} !== {2'd0, 4'd0, 4'd0, 4'd1}) begin
         errors++; $display("FAIL t3_mode_inc_bcd: got %0d%0d:%0d%0d want 00:01", H_in1, H_in0, M_in1, M_in0);
      end
   endtask

   task automatic test_cancel_timeout();
      apply_reset();
      press_inc();
      checks++;
      if (busy !== 1'b0 || {H_in1, H_in0} !== 6'd0) begin
         errors++; $display("FAIL t4_idle_inc: got busy=%0b H=%0d%0d want 0 00", busy, H_in1, H_in0);
      end
      pulse_mode();
      press_inc();
      ld_t = 0; ld_a = 0;
      btn_mode = 1'b1; btn_cancel = 1'b1; tick();
      btn_mode = 1'b0; btn_cancel = 1'b0;
      checks++;
      if (busy !== 1'b0 || edit_fld !== 2'b00) begin
         errors++; $display("FAIL t4_cancel: got busy=%0b fld=%0d want 0 0", busy, edit_fld);
      end
      tick_n(20);
      checks++;
      if (ld_t !== 0 || ld_a !== 0 || {H_in1, H_in0} !== {2'd0, 4'd1}) begin
         errors++; $display("FAIL t4_cancel_noload: got LDt=%0d LDa=%0d H=%0d%0d want 0 0 01",
                            ld_t, ld_a, H_in1, H_in0);
      end
      pulse_mode();
      tick_n(990);
      checks++;
      if (busy !== 1'b1 || edit_fld !== 2'b01) begin
         errors++; $display("FAIL t4_before_timeout: got busy=%0b fld=%0d want 1 1", busy, edit_fld);
      end
      tick_n(20);
      checks++;
      if (busy !== 1'b0 || edit_fld !== 2'b00) begin
         errors++; $display("FAIL t4_timeout: got busy=%0b fld=%0d want 0 0", busy, edit_fld);
      end
      checks++;
      if (ld_t !== 0 || ld_a !== 0 || {H_in1, H_in0} !== {2'd0, 4'd1}) begin
         errors++; $display("FAIL t4_timeout_noload: got LDt=%0d LDa=%0d H=%0d%0d want 0 0 01",
                            ld_t, ld_a, H_in1, H_in0);
      end
   endtask

   task automatic test_reset_in_load();
      apply_reset();
      pulse_mode(); press_inc();
      pulse_mode(); press_inc();
      pulse_mode();
      tick_n(3);
      checks++;
      if (LD_time !== 1'b1) begin
         errors++; $display("FAIL t5_ld_before_reset: got %0b want 1", LD_time);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (LD_time !== 1'b0 || LD_alarm !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL t5_async_drop: got LDt=%0b LDa=%0b busy=%0b want 0 0 0", LD_time, LD_alarm, busy);
      end
      checks++;
      if ({H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin
         errors++; $display("FAIL t5_bcd_clear: got %0d%0d:%0d%0d want 00:00", H_in1, H_in0, M_in1, M_in0);
      end
      tick_n(2);
      reset_n = 1'b1;
      tick_n(3);
      checks++;
      if (busy !== 1'b0 || LD_time !== 1'b0 || {H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin
         errors++; $display("FAIL t5_after_release: got busy=%0b LDt=%0b bcd=%0d%0d:%0d%0d want 0 0 00:00",
                            busy, LD_time, H_in1, H_in0, M_in1, M_in0);
      end
   endtask

`ifdef AUTO_REPEAT_EN
   task automatic test_auto_repeat();
      apply_reset();
      pulse_mode();
      pulse_mode();
      btn_inc = 1'b1;
      tick_n(250);
      btn_inc = 1'b0;
      tick_n(2);
      checks++;
      if ({M_in1, M_in0} !== {4'd0, 4'd3}) begin
         errors++; $display("FAIL t6_repeat: got %0d%0d want 03", M_in1, M_in0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_time_load();
      test_alarm_load();
      test_wrap();
      test_cancel_timeout();
      test_reset_in_load();
`ifdef AUTO_REPEAT_EN
      test_auto_repeat();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
